dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the ungranted external-request cycles before external gets priority (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port c_req, input, 1, core load/store request, held stable until granted.
REQ-005 The block SHALL have port c_we, input, 1, core request is a write (1) or a read (0).
REQ-006 The block SHALL have port c_addr, input, 32, core word address.
REQ-007 The block SHALL have port c_wdata, input, 32, core write data.
REQ-008 The block SHALL have port c_gnt, output, 1, core request is accepted this cycle.
REQ-009 The block SHALL have port c_rvalid, output, 1, c_rdata is valid this cycle.
REQ-010 The block SHALL have port c_rdata, output, 32, registered core read data.
REQ-011 The block SHALL have ports e_req, e_we, e_addr, e_wdata, e_gnt, e_rvalid and e_rdata, with the same directions, widths and meanings as the core set, for the external/debug requester.
REQ-012 The block SHALL have port mem_wr_en, output, 1, data memory write enable.
REQ-013 The block SHALL have port mem_addr, output, 32, data memory address (memory uses bits [7:0]).
REQ-014 The block SHALL have port mem_wr_data, output, 32, data memory write data.
REQ-015 The block SHALL have port mem_rd_data, input, 32, combinational data memory read data.

Function
REQ-016 The block SHALL hold a two-state priority FSM: CORE_PRI (reset state) and EXT_PRI.
REQ-017 At most one of c_gnt and e_gnt SHALL be high in any cycle; both SHALL be 0 while rst_n=0.
REQ-018 Grants SHALL be combinational from the requests and the state: in CORE_PRI, c_gnt=c_req and e_gnt=e_req&!c_req; in EXT_PRI, e_gnt=e_req and c_gnt=c_req&!e_req.
REQ-019 mem_addr and mem_wr_data SHALL select the granted requester's address and write data, and the core's when no grant is active.
REQ-020 mem_wr_en SHALL equal (c_gnt&c_we)|(e_gnt&e_we), so the write lands at the same rising edge.
REQ-021 Read latency SHALL be one cycle: a granted read (we=0) SHALL capture mem_rd_data into x_rdata at that edge and assert x_rvalid for exactly the following cycle.
REQ-022 Writes SHALL never assert rvalid; x_rdata SHALL hold its last value when rvalid=0.
REQ-023 A 4-bit starvation counter SHALL behave as follows at each edge: +1 when e_req=1 and e_gnt=0; cleared when e_gnt=1 or e_req=0; saturates at STARVE_LIMIT.
REQ-024 The FSM SHALL move CORE_PRI->EXT_PRI at the edge where the counter becomes STARVE_LIMIT.
REQ-025 The FSM SHALL move EXT_PRI->CORE_PRI at the edge following any e_gnt, or when e_req drops.
REQ-026 A requester may drop req before grant with no side effect; back-to-back grants to the same requester SHALL be allowed every cycle.
REQ-027 Read then write to the same address in consecutive cycles SHALL return the pre-write data on rvalid.

Reset
REQ-028 On rst_n low, asynchronously: state=CORE_PRI, counter=0, c_rvalid=e_rvalid=0, c_rdata=e_rdata=0, mem_wr_en=0.
REQ-029 A read granted in the cycle reset asserts SHALL never produce rvalid; no memory write SHALL occur while rst_n=0.

Verification
REQ-030 The bench SHALL cover: core write addr 0x10 data 0xDEADBEEF, then core read 0x10 -> c_gnt both cycles, c_rvalid one cycle later, c_rdata=0xDEADBEEF.
REQ-031 The bench SHALL cover: c_req and e_req both high from cycle 0, STARVE_LIMIT=4 -> core granted in cycles 0-3, e_gnt in cycle 4, core granted again in cycle 5.
REQ-032 The bench SHALL cover: only e_req, reading addr 0x20 holding 0x12345678 -> e_gnt same cycle, e_rvalid next cycle, e_rdata=0x12345678, c_rvalid=0 throughout.
REQ-033 The bench SHALL cover: e_req held for 2 cycles under core traffic, then dropped -> counter returns to 0, state stays CORE_PRI, no e_gnt.
REQ-034 The bench SHALL cover: rst_n pulled low mid-read in the grant cycle -> no rvalid, all outputs at REQ-028 values; first request after release is granted normally.
REQ-035 The bench SHALL cover: random mixed traffic for 10k cycles against a reference memory model -> every rdata matches, a grant is never given to both requesters at once, and external wait is never longer than STARVE_LIMIT cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter in front of a single-port data memory. The core
//   normally has priority; an external/debug requester that has waited
//   STARVE_LIMIT cycles without a grant gets priority for one grant.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata         core request (held until granted)
//   c_gnt                             core request accepted this cycle
//   c_rvalid/c_rdata                  core read data, one cycle after grant
//   e_*                               same set for the external requester
//   mem_wr_en/mem_addr/mem_wr_data    memory write port and shared address
//   mem_rd_data                       combinational memory read data
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        e_req,
  input  logic        e_we,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_wdata,
  output logic        e_gnt,
  output logic        e_rvalid,
  output logic [31:0] e_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {CORE_PRI = 1'b0, EXT_PRI = 1'b1} pri_t;

  pri_t       state;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;

  // Grants are forced low while reset is asserted so that no access, and in
  // particular no write, can slip through during reset.
  always_comb begin
    c_gnt = 1'b0;
    e_gnt = 1'b0;
    if (rst_n) begin
      if (state == CORE_PRI) begin
        c_gnt = c_req;
        e_gnt = e_req & ~c_req;
      end else begin
        e_gnt = e_req;
        c_gnt = c_req & ~e_req;
      end
    end
  end

  // The core owns the address/data bus whenever the external side is not granted.
  always_comb begin
    mem_addr    = e_gnt ? e_addr  : c_addr;
    mem_wr_data = e_gnt ? e_wdata : c_wdata;
    mem_wr_en   = (c_gnt & c_we) | (e_gnt & e_we);
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (e_gnt || !e_req) begin
      starve_cnt_nxt = 4'd0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // Priority FSM and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CORE_PRI;
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      case (state)
        CORE_PRI: if (starve_cnt_nxt == LIMIT) state <= EXT_PRI;
        EXT_PRI:  if (e_gnt || !e_req)         state <= CORE_PRI;
        default:  state <= CORE_PRI;
      endcase
    end
  end

  // Read return stage: data captured at the grant edge, valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      c_rdata  <= 32'd0;
      e_rdata  <= 32'd0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      e_rvalid <= e_gnt & ~e_we;
      if (c_gnt && !c_we) c_rdata <= mem_rd_data;
      if (e_gnt && !e_we) e_rdata <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 0, c_we = 0, e_req = 0, e_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, e_addr = 0, e_wdata = 0;
  logic        c_gnt, c_rvalid, e_gnt, e_rvalid, mem_wr_en;
  logic [31:0] c_rdata, e_rdata, mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  int n_chk = 0;
  int n_pass = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cr, cw; logic [31:0] ca, cd;
    logic        er, ew; logic [31:0] ea, ed;
    logic        x_cg, x_eg, x_we, x_crv; logic [31:0] x_crd;
    logic        x_erv; logic [31:0] x_erd;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic er, logic ew, logic [31:0] ea, logic [31:0] ed,
                              logic x_cg, logic x_eg, logic x_we,
                              logic x_crv, logic [31:0] x_crd, logic x_erv, logic [31:0] x_erd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
    v.x_cg = x_cg; v.x_eg = x_eg; v.x_we = x_we;
    v.x_crv = x_crv; v.x_crd = x_crd; v.x_erv = x_erv; v.x_erd = x_erd;
    return v;
  endfunction

  // random-traffic state
  logic        cp, cpw, ep, epw;
  logic [31:0] cpa, cpd, epa, epd;
  logic        exp_crv, exp_erv;
  logic [31:0] exp_crd, exp_erd;
  int          e_wait;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h20] = 32'h12345678;

    // reset state
    #2;
    check("rst_c_gnt", {31'd0, c_gnt}, 0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 0);
    check("rst_c_rvalid", {31'd0, c_rvalid}, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_e_rdata", e_rdata, 0);
    step(); step();
    rst_n = 1'b1;

    //                c_req we addr        wdata          e_req we addr  wdata          cg eg we crv crd            erv erd
    vecs[0]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,                      1,0,1, 0,32'h0,        0,32'h0);
    vecs[1]  = mk(1,0,32'h10,0,            0,0,0,0,                      1,0,0, 0,32'h0,        0,32'h0);
    vecs[2]  = mk(0,0,0,0,                 0,0,0,0,                      0,0,0, 1,32'hDEADBEEF, 0,32'h0);
    vecs[3]  = mk(0,0,0,0,                 1,0,32'h20,0,                 0,1,0, 0,32'hDEADBEEF, 0,32'h0);
    vecs[4]  = mk(0,0,0,0,                 0,0,0,0,                      0,0,0, 0,32'hDEADBEEF, 1,32'h12345678);
    vecs[5]  = mk(1,0,32'h20,0,            1,1,32'h20,32'hCAFEF00D,      1,0,0, 0,32'hDEADBEEF, 0,32'h12345678);
    vecs[6]  = mk(0,0,0,0,                 1,1,32'h20,32'hCAFEF00D,      0,1,1, 1,32'h12345678, 0,32'h12345678);
    vecs[7]  = mk(1,0,32'h20,0,            0,0,0,0,                      1,0,0, 0,32'h12345678, 0,32'h12345678);
    vecs[8]  = mk(0,0,0,0,                 0,0,0,0,                      0,0,0, 1,32'hCAFEF00D, 0,32'h12345678);
    vecs[9]  = mk(1,0,32'h30,0,            0,0,0,0,                      1,0,0, 0,32'hCAFEF00D, 0,32'h12345678);
    vecs[10] = mk(1,1,32'h30,32'h55AA55AA, 0,0,0,0,                      1,0,1, 1,32'h0,        0,32'h12345678);
    vecs[11] = mk(1,0,32'h30,0,            0,0,0,0,                      1,0,0, 0,32'h0,        0,32'h12345678);
    vecs[12] = mk(0,0,0,0,                 0,0,0,0,                      0,0,0, 1,32'h55AA55AA, 0,32'h12345678);
    vecs[13] = mk(1,0,32'h40,0,            1,0,32'h44,0,                 1,0,0, 0,32'h55AA55AA, 0,32'h12345678);
    vecs[14] = mk(1,0,32'h40,0,            1,0,32'h44,0,                 1,0,0, 1,32'h0,        0,32'h12345678);
    vecs[15] = mk(1,0,32'h40,0,            0,0,0,0,                      1,0,0, 1,32'h0,        0,32'h12345678);
    vecs[16] = mk(0,0,0,0,                 0,0,0,0,                      0,0,0, 1,32'h0,        0,32'h12345678);

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].cr, vecs[k].cw, vecs[k].ca, vecs[k].cd,
            vecs[k].er, vecs[k].ew, vecs[k].ea, vecs[k].ed);
      #1;
      check($sformatf("v%0d_c_gnt", k), {31'd0, c_gnt}, {31'd0, vecs[k].x_cg});
      check($sformatf("v%0d_e_gnt", k), {31'd0, e_gnt}, {31'd0, vecs[k].x_eg});
      check($sformatf("v%0d_wr_en", k), {31'd0, mem_wr_en}, {31'd0, vecs[k].x_we});
      check($sformatf("v%0d_c_rvalid", k), {31'd0, c_rvalid}, {31'd0, vecs[k].x_crv});
      check($sformatf("v%0d_c_rdata", k), c_rdata, vecs[k].x_crd);
      check($sformatf("v%0d_e_rvalid", k), {31'd0, e_rvalid}, {31'd0, vecs[k].x_erv});
      check($sformatf("v%0d_e_rdata", k), e_rdata, vecs[k].x_erd);
      step();
    end

    // Starvation: both requesting, external wins only in cycle LIM
    for (int cyc = 0; cyc <= LIM + 1; cyc++) begin
      drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
      #1;
      check($sformatf("starve%0d_c_gnt", cyc), {31'd0, c_gnt}, (cyc == LIM) ? 0 : 1);
      check($sformatf("starve%0d_e_gnt", cyc), {31'd0, e_gnt}, (cyc == LIM) ? 1 : 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Reset asserted in the cycle a read is granted
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    check("rstmid_gnt_before", {31'd0, c_gnt}, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_c_gnt", {31'd0, c_gnt}, 0);
    check("rstmid_c_rdata", c_rdata, 0);
    drive(1, 1, 32'h50, 32'h11111111, 1, 1, 32'h50, 32'h22222222);
    #1;
    check("rstmid_wr_en", {31'd0, mem_wr_en}, 0);
    step();
    check("rstmid_c_rvalid", {31'd0, c_rvalid}, 0);
    check("rstmid_e_rvalid", {31'd0, e_rvalid}, 0);
    check("rstmid_e_rdata", e_rdata, 0);
    check("rstmid_e_gnt", {31'd0, e_gnt}, 0);
    rst_n = 1'b1;
    drive(1, 0, 32'h50, 0, 0, 0, 0, 0);
    #1;
    check("postrst_c_gnt", {31'd0, c_gnt}, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("postrst_c_rvalid", {31'd0, c_rvalid}, 1);
    check("postrst_c_rdata", c_rdata, 32'h0);
    step();

    // Random mixed traffic against a reference memory
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    cp = 0; ep = 0; exp_crv = 0; exp_erv = 0; exp_crd = 0; exp_erd = 0; e_wait = 0;
    cpw = 0; epw = 0; cpa = 0; cpd = 0; epa = 0; epd = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; cpw = $urandom_range(0, 1) == 1;
        cpa = 32'h80 + $urandom_range(0, 7); cpd = $urandom;
      end
      if (!ep && $urandom_range(0, 2) == 0) begin
        ep = 1; epw = $urandom_range(0, 1) == 1;
        epa = 32'h80 + $urandom_range(0, 7); epd = $urandom;
      end
      drive(cp, cpw, cpa, cpd, ep, epw, epa, epd);
      #1;
      check("rnd_c_rvalid", {31'd0, c_rvalid}, {31'd0, exp_crv});
      if (exp_crv) check("rnd_c_rdata", c_rdata, exp_crd);
      check("rnd_e_rvalid", {31'd0, e_rvalid}, {31'd0, exp_erv});
      if (exp_erv) check("rnd_e_rdata", e_rdata, exp_erd);
      check("rnd_excl", {31'd0, c_gnt & e_gnt}, 0);
      check("rnd_work", {31'd0, c_gnt | e_gnt}, {31'd0, cp | ep});
      exp_crv = 0; exp_erv = 0;
      if (c_gnt && cp) begin
        if (cpw) ref_mem[cpa[7:0]] = cpd;
        else begin exp_crv = 1; exp_crd = ref_mem[cpa[7:0]]; end
        cp = 0;
      end else if (e_gnt && ep) begin
        if (epw) ref_mem[epa[7:0]] = epd;
        else begin exp_erv = 1; exp_erd = ref_mem[epa[7:0]]; end
        ep = 0;
        e_wait = 0;
      end
      if (ep) begin
        e_wait++;
        if (e_wait > LIM) check("rnd_e_wait", e_wait, LIM);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
